// File: rtl/pong_video_pkg.sv
// pong_video_pkg: 640x480@60 timing defaults, colour type and constants
package pong_video_pkg;
  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D = 16;
  localparam int H_SYNC_D = 96;
  localparam int H_BP_D = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D = 10;
  localparam int V_SYNC_D = 2;
  localparam int V_BP_D = 33;
  localparam int COLOR_BITS = 4;
  localparam int CW = 12;
  typedef struct packed {
    logic [COLOR_BITS-1:0] r;
    logic [COLOR_BITS-1:0] g;
    logic [COLOR_BITS-1:0] b;
  } rgb_t;
  localparam logic [COLOR_BITS-1:0] C_MSB = {1'b1, {(COLOR_BITS-1){1'b0}}};
  localparam rgb_t COLOR_WHITE = '{r: '1, g: '1, b: '1};
  localparam rgb_t COLOR_GREY = '{r: C_MSB, g: C_MSB, b: C_MSB};
  localparam rgb_t COLOR_BLACK = '0;
  function automatic logic in_span(input logic [CW-1:0] v, input logic [CW-1:0] lo, input logic [CW-1:0] len);
    return v >= lo && v < lo + len;
  endfunction
endpackage

// File: rtl/vga_timing.sv
// vga_timing: h/v counters with sync, active and frame-end decode
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int H_W = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int V_W = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic           clk,
  input  logic           rst,
  output logic [H_W-1:0] o_h_cnt,
  output logic [V_W-1:0] o_v_cnt,
  output logic           o_hsync,
  output logic           o_vsync,
  output logic           o_active,
  output logic           o_frame_end
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  logic [H_W-1:0] r_h;
  logic [V_W-1:0] r_v;
  logic w_h_last, w_v_last;
  assign w_h_last = r_h == H_W'(H_TOTAL - 1);
  assign w_v_last = r_v == V_W'(V_TOTAL - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_h <= '0;
      r_v <= '0;
    end else begin
      r_h <= w_h_last ? '0 : r_h + 1'b1;
      if (w_h_last) r_v <= w_v_last ? '0 : r_v + 1'b1;
    end
  assign o_h_cnt = r_h;
  assign o_v_cnt = r_v;
  assign o_hsync = !(r_h >= H_W'(H_ACTIVE + H_FP) && r_h < H_W'(H_ACTIVE + H_FP + H_SYNC));
  assign o_vsync = !(r_v >= V_W'(V_ACTIVE + V_FP) && r_v < V_W'(V_ACTIVE + V_FP + V_SYNC));
  assign o_active = r_h < H_W'(H_ACTIVE) && r_v < V_W'(V_ACTIVE);
  assign o_frame_end = w_h_last && w_v_last;
endmodule

// File: rtl/pong_vga_renderer.sv
// pong_vga_renderer: 2-stage pong playfield renderer; PONG_CENTER_NET_EN adds a dashed centre net
module pong_vga_renderer import pong_video_pkg::*; #(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP = H_FP_D,
  parameter int H_SYNC = H_SYNC_D,
  parameter int H_BP = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP = V_FP_D,
  parameter int V_SYNC = V_SYNC_D,
  parameter int V_BP = V_BP_D,
  parameter int PADDLE_1_X = 20,
  parameter int PADDLE_2_X = 612,
  parameter int PADDLE_WIDTH = 8,
  parameter int PADDLE_HEIGHT = 64,
  parameter int BALL_SIDE_SIZE = 8,
  parameter int BORDER_PIXEL_WIDTH = 4,
  parameter int PX_W = $clog2(H_ACTIVE + 1) + 1,
  parameter int PY_W = $clog2(V_ACTIVE + 1) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PY_W-1:0]       paddle_1_pos,
  input  logic [PY_W-1:0]       paddle_2_pos,
  input  logic [PX_W-1:0]       ball_pos_x,
  input  logic [PY_W-1:0]       ball_pos_y,
  output logic                  hsync,
  output logic                  vsync,
  output logic [COLOR_BITS-1:0] red,
  output logic [COLOR_BITS-1:0] green,
  output logic [COLOR_BITS-1:0] blue,
  output logic                  frame_start
);
  localparam int H_W = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int V_W = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  logic [H_W-1:0] w_h_cnt;
  logic [V_W-1:0] w_v_cnt;
  logic w_hsync, w_vsync, w_active, w_frame_end;
  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .H_W(H_W), .V_W(V_W)
  ) u_timing (
    .clk(clk), .rst(rst), .o_h_cnt(w_h_cnt), .o_v_cnt(w_v_cnt),
    .o_hsync(w_hsync), .o_vsync(w_vsync), .o_active(w_active), .o_frame_end(w_frame_end)
  );
  logic [PY_W-1:0] r_p1, r_p2, r_by;
  logic [PX_W-1:0] r_bx;
  // Positions only move at the frame boundary so a frame never tears
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_p1 <= '0;
      r_p2 <= '0;
      r_bx <= '0;
      r_by <= '0;
    end else if (w_frame_end) begin
      r_p1 <= paddle_1_pos;
      r_p2 <= paddle_2_pos;
      r_bx <= ball_pos_x;
      r_by <= ball_pos_y;
    end
  logic [CW-1:0] w_x, w_y;
  logic w_ball, w_pad, w_border, w_start;
  assign w_x = CW'(w_h_cnt);
  assign w_y = CW'(w_v_cnt);
  assign w_ball = in_span(w_x, CW'(r_bx), CW'(BALL_SIDE_SIZE)) && in_span(w_y, CW'(r_by), CW'(BALL_SIDE_SIZE));
  assign w_pad = (in_span(w_x, CW'(PADDLE_1_X), CW'(PADDLE_WIDTH)) && in_span(w_y, CW'(r_p1), CW'(PADDLE_HEIGHT)))
              || (in_span(w_x, CW'(PADDLE_2_X), CW'(PADDLE_WIDTH)) && in_span(w_y, CW'(r_p2), CW'(PADDLE_HEIGHT)));
  assign w_border = w_y < CW'(BORDER_PIXEL_WIDTH) || w_y >= CW'(V_ACTIVE - BORDER_PIXEL_WIDTH);
  assign w_start = w_h_cnt == '0 && w_v_cnt == '0;
  logic r1_ball, r1_pad, r1_border, r1_active, r1_hsync, r1_vsync, r1_start;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r1_ball <= 1'b0;
      r1_pad <= 1'b0;
      r1_border <= 1'b0;
      r1_active <= 1'b0;
      r1_hsync <= 1'b1;
      r1_vsync <= 1'b1;
      r1_start <= 1'b0;
    end else begin
      r1_ball <= w_ball;
      r1_pad <= w_pad;
      r1_border <= w_border;
      r1_active <= w_active;
      r1_hsync <= w_hsync;
      r1_vsync <= w_vsync;
      r1_start <= w_start;
    end
  logic w_grey;
`ifdef PONG_CENTER_NET_EN
  logic w_net, r1_net;
  assign w_net = (w_x == CW'(H_ACTIVE / 2 - 1) || w_x == CW'(H_ACTIVE / 2)) && !w_y[3];
  always_ff @(posedge clk or negedge rst)
    if (!rst) r1_net <= 1'b0;
    else r1_net <= w_net;
  assign w_grey = r1_border || r1_net;
`else
  assign w_grey = r1_border;
`endif
  rgb_t w_rgb, r_rgb;
  assign w_rgb = !r1_active ? COLOR_BLACK : (r1_ball || r1_pad) ? COLOR_WHITE : w_grey ? COLOR_GREY : COLOR_BLACK;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_rgb <= COLOR_BLACK;
      hsync <= 1'b1;
      vsync <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      r_rgb <= w_rgb;
      hsync <= r1_hsync;
      vsync <= r1_vsync;
      frame_start <= r1_start;
    end
  assign red = r_rgb.r;
  assign green = r_rgb.g;
  assign blue = r_rgb.b;
endmodule

// File: tb/tb_pong_vga_renderer.sv
// tb_pong_vga_renderer: per-cycle model check of a scaled-down playfield plus literal pixel/timing checks
module tb_pong_vga_renderer;
  localparam int HA = 40, HFP = 4, HS = 8, HBP = 4;
  localparam int VA = 30, VFP = 2, VS = 2, VBP = 3;
  localparam int P1X = 2, P2X = 34, PW = 2, PH = 6, B = 3, BW = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam int NF = 16;
  logic clk = 0, rst = 0;
  logic [5:0] p1 = 0, p2 = 0, by = 0;
  logic [6:0] bx = 0;
  logic hsync, vsync, frame_start;
  logic [3:0] red, green, blue;
  int checks = 0, errors = 0, e = 0;
  int sbx[NF], sby[NF], sp1[NF], sp2[NF];
  int fs_q[$];
  always #5 clk = ~clk;
  pong_vga_renderer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .PADDLE_1_X(P1X), .PADDLE_2_X(P2X), .PADDLE_WIDTH(PW), .PADDLE_HEIGHT(PH),
    .BALL_SIDE_SIZE(B), .BORDER_PIXEL_WIDTH(BW)
  ) dut (
    .clk(clk), .rst(rst), .paddle_1_pos(p1), .paddle_2_pos(p2),
    .ball_pos_x(bx), .ball_pos_y(by), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue), .frame_start(frame_start)
  );
  function automatic logic [11:0] exp_rgb(int x, int y, int ebx, int eby, int ep1, int ep2);
    if (x >= HA || y >= VA) return 12'h000;
    if (x >= ebx && x < ebx + B && y >= eby && y < eby + B) return 12'hfff;
    if (x >= P1X && x < P1X + PW && y >= ep1 && y < ep1 + PH) return 12'hfff;
    if (x >= P2X && x < P2X + PW && y >= ep2 && y < ep2 + PH) return 12'hfff;
`ifdef PONG_CENTER_NET_EN
    if ((x == HA / 2 - 1 || x == HA / 2) && (y % 16) < 8) return 12'h888;
`endif
    if (y < BW || y >= VA - BW) return 12'h888;
    return 12'h000;
  endfunction
  // e = clock edges since reset release; frame f is drawn with inputs present at edge f*FT
  always @(posedge clk or negedge rst)
    if (!rst) begin
      e <= 0;
      sbx[0] <= 0;
      sby[0] <= 0;
      sp1[0] <= 0;
      sp2[0] <= 0;
    end else begin
      e <= e + 1;
      if ((e + 1) % FT == 0 && (e + 1) / FT < NF) begin
        sbx[(e + 1) / FT] <= int'(bx);
        sby[(e + 1) / FT] <= int'(by);
        sp1[(e + 1) / FT] <= int'(p1);
        sp2[(e + 1) / FT] <= int'(p2);
      end
    end
  always @(negedge clk) begin
    logic [14:0] got, exp;
    int p, f, q, x, y;
    got = {hsync, vsync, frame_start, red, green, blue};
    if (!rst || e < 2) exp = 15'h6000;
    else begin
      p = e - 2;
      f = p / FT;
      q = p % FT;
      x = q % HT;
      y = q / HT;
      if (f >= NF) f = NF - 1;
      exp = {!(x >= HA + HFP && x < HA + HFP + HS), !(y >= VA + VFP && y < VA + VFP + VS), q == 0,
             exp_rgb(x, y, sbx[f], sby[f], sp1[f], sp2[f])};
    end
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL pixel e=%0d got=%h exp=%h", e, got, exp);
    end
  end
  always @(negedge clk) if (rst && frame_start) fs_q.push_back(e);
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  task automatic wait_sig(input bit vs_sel, input logic val, output int at);
    at = -1;
    for (int n = 0; n < 3 * FT; n++) begin
      @(negedge clk);
      if ((vs_sel ? vsync : hsync) == val) begin
        at = e;
        break;
      end
    end
  endtask
  task automatic pix(input string name, input int f, input int x, input int y, input int exp);
    int t, n;
    t = f * FT + y * HT + x + 2;
    n = 0;
    while (e != t && n < 4 * FT) begin
      @(negedge clk);
      n++;
    end
    chk(name, (e == t) ? int'({red, green, blue}) : -1, exp);
  endtask
  initial begin
    int at;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", int'({hsync, vsync, frame_start, red, green, blue}), 'h6000);
    rst = 1;
    bx = 10; by = 12; p1 = 5; p2 = 5;
    wait_sig(0, 0, at); chk("hsync_fall", at, 46);
    wait_sig(0, 1, at); chk("hsync_rise", at, 54);
    wait_sig(1, 0, at); chk("vsync_fall", at, 1794);
    wait_sig(1, 1, at); chk("vsync_rise", at, 1906);
    pix("pad1_top", 1, 2, 5, 'hfff);
    pix("pad2_top", 1, 34, 5, 'hfff);
    pix("pad1_bottom", 1, 3, 10, 'hfff);
    pix("pad1_below", 1, 2, 11, 'h000);
    pix("ball_left_out", 1, 9, 12, 'h000);
    pix("ball_corner", 1, 10, 12, 'hfff);
    pix("ball_right_out", 1, 13, 12, 'h000);
    pix("f2_ball_old", 2, 10, 12, 'hfff);
    pix("f2_ball_new", 2, 25, 12, 'h000);
    pix("f2_line15", 2, 0, 15, 'h000);
    bx = 25;
    pix("f3_ball_old", 3, 10, 12, 'h000);
    pix("f3_ball_new", 3, 25, 12, 'hfff);
    bx = 2; by = 8;
    pix("border_top", 4, 30, 1, 'h888);
    pix("bg_near_pad", 4, 4, 5, 'h000);
    pix("overlap", 4, 3, 9, 'hfff);
    pix("ball_only", 4, 4, 9, 'hfff);
    pix("outside_active", 4, 45, 10, 'h000);
    pix("above_border", 4, 30, 27, 'h000);
    pix("border_bottom", 4, 30, 28, 'h888);
    chk("fs_first", fs_q.size() > 0 ? fs_q[0] : -1, 2);
    chk("fs_gap1", fs_q.size() > 1 ? fs_q[1] - fs_q[0] : -1, FT);
    chk("fs_gap2", fs_q.size() > 2 ? fs_q[2] - fs_q[1] : -1, FT);
    pix("pre_reset", 5, 0, 20, 'h000);
    @(posedge clk);
    #3 rst = 0;
    #1 chk("async_reset", int'({hsync, vsync, frame_start, red, green, blue}), 'h6000);
    fs_q.delete();
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1;
    wait_sig(0, 0, at); chk("hsync_fall_2", at, 46);
    wait_sig(0, 1, at); chk("hsync_rise_2", at, 54);
    chk("fs_first_2", fs_q.size() > 0 ? fs_q[0] : -1, 2);
    pix("overlap_2", 1, 3, 9, 'hfff);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
